// File: rtl/bram_port_ctrl.sv
// Front-end for a read-first, 1-cycle-latency true-dual-port BRAM: port A serves reads,
// port B serves writes and the zeroing sweep, with handshakes and write-to-read forwarding.
module bram_port_ctrl #(
    parameter int unsigned DATA_WIDTH     = 88,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clka,
    input  logic                  aresetn,
    input  logic                  clear_req,
    output logic                  busy_clearing,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_resp_valid,
    input  logic                  rd_resp_ready,
    output logic [DATA_WIDTH-1:0] rd_resp_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic                  bram_ena,
    output logic                  bram_wea,
    input  logic [DATA_WIDTH-1:0] bram_douta,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    output logic                  bram_enb,
    output logic                  bram_web,
    output logic [DATA_WIDTH-1:0] bram_dinb
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam state_t                RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic                  fwd_flag_q, fwd_flag_d;
    logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

    logic clearing;
    logic idle;
    logic rd_fire;
    logic wr_fire;

    // Gated with aresetn so the reset-time CLEAR state shows nothing until release.
    assign clearing = (state_q == S_CLEAR) && aresetn;
    assign idle     = (state_q == S_IDLE) && aresetn;

    assign busy_clearing = clearing;
    assign wr_ready      = idle;
    assign rd_req_ready  = idle && (!rvalid_q || rd_resp_ready);
    assign wr_fire       = wr_valid && wr_ready;
    assign rd_fire       = rd_req_valid && rd_req_ready;

    assign bram_addra    = rd_addr;
    assign bram_ena      = rd_fire;
    assign bram_wea      = 1'b0;

    assign rd_resp_valid = rvalid_q;
    assign rd_resp_data  = fwd_flag_q ? fwd_data_q : bram_douta;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                if (clear_req) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bram_enb   = 1'b0;
        bram_web   = 1'b0;
        bram_addrb = '0;
        bram_dinb  = '0;
        if (clearing) begin
            bram_enb   = 1'b1;
            bram_web   = 1'b1;
            bram_addrb = cnt_q;
        end else if (wr_fire) begin
            bram_enb   = 1'b1;
            bram_web   = 1'b1;
            bram_addrb = wr_addr;
            bram_dinb  = wr_data;
        end
    end

    // Forward state only moves on a new accept, so a stalled response keeps its snapshot.
    always_comb begin
        rvalid_d   = rvalid_q;
        fwd_flag_d = fwd_flag_q;
        fwd_data_d = fwd_data_q;
        if (rd_fire) begin
            rvalid_d   = 1'b1;
            fwd_flag_d = wr_fire && (wr_addr == rd_addr);
            if (wr_fire && (wr_addr == rd_addr)) begin
                fwd_data_d = wr_data;
            end
        end else if (rd_resp_ready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clka or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= RESET_STATE;
            cnt_q      <= '0;
            rvalid_q   <= 1'b0;
            fwd_flag_q <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rvalid_q   <= rvalid_d;
            fwd_flag_q <= fwd_flag_d;
            fwd_data_q <= fwd_data_d;
        end
    end

endmodule
